bch_encode_serial: RTL

BCH_ENCODE_SERIAL -- requirements
Module: bch_encode_serial

---
 rtl/bch_encode_serial.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bch_encode_serial.sv
// ---------------------------------------------------------------------------
// bch_encode_serial
//
// Bit-serial systematic BCH encoder. Message bits stream in one per accepted
// beat (highest-degree coefficient first) and pass straight through to the
// output. After K data bits, the P-bit remainder of x^P*m(x) mod GEN is
// shifted out, x^(P-1) coefficient first. Each codeword is N = K+P bits.
//
// Handshake (both sides): a bit moves when valid && ready are both high at a
// rising clk edge. Valid must not depend on ready. The output stage is a
// single register that holds its contents while m_valid=1 and m_ready=0.
//
// Parameters:
//   M   - GF(2^M) field size, N = 2^M-1
//   K   - data bits per codeword
//   P   - parity bits per codeword (K+P must equal N)
//   GEN - generator polynomial, P+1 bits, bit i = coefficient of x^i
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   s_valid   in   input data bit offered
//   s_ready   out  encoder accepts the input bit this cycle
//   s_data    in   data bit
//   m_valid   out  output codeword bit valid
//   m_ready   in   downstream accepts the output bit
//   m_data    out  codeword bit (K data bits, then P parity bits)
//   m_first   out  high with the first bit of each codeword
//   m_last    out  high with the last parity bit of each codeword
//   dbg_state out  FSM state (0 = DATA, 1 = PARITY), for checkers
//
// Build option:
//   BCH_ENCODE_PARITY_INVERT_EN - when defined, parity bits are output
//   inverted; the internal LFSR is unaffected.
// ---------------------------------------------------------------------------
module bch_encode_serial #(
  parameter int          M   = 4,
  parameter int          K   = 7,
  parameter int          P   = 8,
  parameter logic [P:0]  GEN = 9'h1D1
) (
  input  logic clk,
  input  logic reset,
  input  logic s_valid,
  output logic s_ready,
  input  logic s_data,
  output logic m_valid,
  input  logic m_ready,
  output logic m_data,
  output logic m_first,
  output logic m_last,
  output logic dbg_state
);

  localparam int N    = (1 << M) - 1;
  localparam int MAXC = (K > P) ? K : P;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(K - 1);
  localparam logic [CW-1:0] P_LAST = CW'(P - 1);

  // Reject inconsistent parameter sets at elaboration time.
  if ((K + P) != N || GEN[P] != 1'b1) begin : g_param_check
    $error("bch_encode_serial: K+P must equal 2^M-1 and GEN[P] must be 1");
  end

  typedef enum logic {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [P-1:0]    r_lfsr, w_lfsr_nxt;
  logic            r_m_data, w_m_data_nxt;
  logic            r_m_valid, w_m_valid_nxt;
  logic            r_m_first, w_m_first_nxt;
  logic            r_m_last, w_m_last_nxt;

  logic            w_stage_free;
  logic            w_accept;
  logic            w_fb;
  logic            w_parity_bit;

  // Output register may load when empty or being drained this cycle.
  assign w_stage_free = !r_m_valid || m_ready;
  assign s_ready      = (r_state == ST_DATA) && w_stage_free && !reset;
  assign w_accept     = s_valid && s_ready;
  assign w_fb         = s_data ^ r_lfsr[P-1];

`ifdef BCH_ENCODE_PARITY_INVERT_EN
  assign w_parity_bit = ~r_lfsr[P-1];
`else
  assign w_parity_bit = r_lfsr[P-1];
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_lfsr_nxt    = r_lfsr;
    w_m_data_nxt  = r_m_data;
    w_m_valid_nxt = r_m_valid;
    w_m_first_nxt = r_m_first;
    w_m_last_nxt  = r_m_last;

    case (r_state)
      ST_DATA: begin
        if (w_accept) begin
          w_m_data_nxt  = s_data;
          w_m_valid_nxt = 1'b1;
          w_m_first_nxt = (r_cnt == '0);
          w_m_last_nxt  = 1'b0;
          // Division by GEN: feedback folds the generator into the remainder.
          w_lfsr_nxt    = (r_lfsr << 1) ^ ({P{w_fb}} & GEN[P-1:0]);
          if (r_cnt == K_LAST) begin
            w_state_nxt = ST_PARITY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end else if (m_ready) begin
          w_m_valid_nxt = 1'b0;
          w_m_first_nxt = 1'b0;
          w_m_last_nxt  = 1'b0;
        end
      end
      ST_PARITY: begin
        if (w_stage_free) begin
          w_m_data_nxt  = w_parity_bit;
          w_m_valid_nxt = 1'b1;
          w_m_first_nxt = 1'b0;
          w_m_last_nxt  = (r_cnt == P_LAST);
          w_lfsr_nxt    = r_lfsr << 1;
          if (r_cnt == P_LAST) begin
            w_lfsr_nxt  = '0;
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_DATA;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_DATA;
      r_cnt     <= '0;
      r_lfsr    <= '0;
      r_m_data  <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_first <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_m_data  <= w_m_data_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_m_first <= w_m_first_nxt;
      r_m_last  <= w_m_last_nxt;
    end
  end

  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign m_first   = r_m_first;
  assign m_last    = r_m_last;
  assign dbg_state = r_state;

endmodule
